// File: rtl/traffic_pkg.sv
// Shared light/phase encodings and the per-approach light helper for traffic_controller_n.
// Pure definitions, no latency; no backpressure.
package traffic_pkg;

    localparam logic [1:0] LT_RED    = 2'd0;
    localparam logic [1:0] LT_YELLOW = 2'd1;
    localparam logic [1:0] LT_GREEN  = 2'd2;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_t;

    // Light shown by one approach, given the phase and whether it owns it.
    function automatic logic [1:0] light_lane(input phase_t ph, input logic owner);
        logic [1:0] lane;
        lane = LT_RED;
        if (owner && ph == PH_GREEN)  lane = LT_GREEN;
        if (owner && ph == PH_YELLOW) lane = LT_YELLOW;
        return lane;
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Round-robin pick of the first demanding approach after the current one (current excluded).
// Combinational, zero latency; no backpressure.
module traffic_rr_pick #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-1:0]         i_demand,
    input  logic [$clog2(NUM_WAYS)-1:0] i_cur,
    output logic [$clog2(NUM_WAYS)-1:0] o_next,
    output logic                        o_vld
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    // Scan from the farthest offset down so the nearest demanding way wins.
    always_comb begin
        o_next = '0;
        o_vld  = 1'b0;
        for (int off = NUM_WAYS - 1; off >= 1; off--) begin
            if (i_demand[(int'(i_cur) + off) % NUM_WAYS]) begin
                o_next = WAY_W'((int'(i_cur) + off) % NUM_WAYS);
                o_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_controller_n.sv
// N-approach intersection controller: round-robin green on latched demand, way 0 default, emergency all-red.
// Outputs registered; inputs act on the next clock edge; no backpressure.
module traffic_controller_n
    import traffic_pkg::*;
#(
    parameter int NUM_WAYS  = 4,
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_WAYS-1:0]         i_sensor,
    input  logic                        i_emergency,
    output logic [2*NUM_WAYS-1:0]       o_light,
    output logic [$clog2(NUM_WAYS)-1:0] o_green_way,
    output logic [1:0]                  o_phase
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_L = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] RED_L = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] T_SAT = '1;
    localparam logic [2*NUM_WAYS-1:0] RESET_LIGHT = {{(2*NUM_WAYS-2){1'b0}}, LT_GREEN};

    phase_t               r_phase, w_phase_n;
    logic [WAY_W-1:0]     r_green_way, w_way_n;
    logic [WAY_W-1:0]     r_next_way, w_next_way_n;
    logic [CNT_W-1:0]     r_timer, w_timer_n;
    logic [NUM_WAYS-1:0]  r_pending, w_pending_n;
    logic [2*NUM_WAYS-1:0] r_light, w_light_n;

    logic [NUM_WAYS-1:0]  w_demand;
    logic [WAY_W-1:0]     w_pick_way;
    logic                 w_other;
    logic                 w_enter_green;

    // Main road always wants the phase back when someone else holds it.
    always_comb begin
        w_demand = r_pending | i_sensor;
        if (r_green_way != '0) w_demand[0] = 1'b1;
    end

    traffic_rr_pick #(.NUM_WAYS(NUM_WAYS)) u_pick (
        .i_demand (w_demand),
        .i_cur    (r_green_way),
        .o_next   (w_pick_way),
        .o_vld    (w_other)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase     <= PH_GREEN;
            r_green_way <= '0;
            r_next_way  <= '0;
            r_timer     <= '0;
            r_pending   <= '0;
            r_light     <= RESET_LIGHT;
        end else begin
            r_phase     <= w_phase_n;
            r_green_way <= w_way_n;
            r_next_way  <= w_next_way_n;
            r_timer     <= w_timer_n;
            r_pending   <= w_pending_n;
            r_light     <= w_light_n;
        end
    end

    always_comb begin
        w_phase_n    = r_phase;
        w_way_n      = r_green_way;
        w_next_way_n = r_next_way;
        case (r_phase)
            PH_GREEN: begin
                if (i_emergency ||
                    (w_other && ((r_timer >= MIN_L && !i_sensor[r_green_way]) || r_timer >= MAX_L))) begin
                    w_phase_n    = PH_YELLOW;
                    w_next_way_n = i_emergency ? '0 : w_pick_way;
                end
            end
            PH_YELLOW: begin
                if (i_emergency) w_next_way_n = '0;
                if (r_timer == YEL_L) w_phase_n = PH_ALLRED;
            end
            PH_ALLRED: begin
                if (i_emergency) begin
                    w_next_way_n = '0;
                end else if (r_timer == RED_L) begin
                    w_phase_n = PH_GREEN;
                    w_way_n   = r_next_way;
                end
            end
            default: w_phase_n = PH_GREEN;
        endcase
    end

    // Preempted all-red keeps the timer at 0 so release always gets a full clearance.
    always_comb begin
        w_enter_green = (r_phase == PH_ALLRED) && (w_phase_n == PH_GREEN);
        if (w_phase_n != r_phase || (r_phase == PH_ALLRED && i_emergency))
            w_timer_n = '0;
        else if (r_timer != T_SAT)
            w_timer_n = r_timer + 1'b1;
        else
            w_timer_n = r_timer;

        w_pending_n = r_pending;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (i_sensor[i] && !(r_phase == PH_GREEN && r_green_way == WAY_W'(i)))
                w_pending_n[i] = 1'b1;
            if (w_enter_green && r_next_way == WAY_W'(i))
                w_pending_n[i] = 1'b0;
        end

        w_light_n = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            w_light_n[2*i +: 2] = light_lane(w_phase_n, w_way_n == WAY_W'(i));
    end

    assign o_light     = r_light;
    assign o_green_way = r_green_way;
    assign o_phase     = r_phase;

endmodule
